dac_serial_tx_multi: RTL
========================

Name: dac_serial_tx_multi

Overview:
Parametrised multi-channel serial DAC transmitter. It replaces the single-channel, fixed 12-bit, externally-clocked DAC protocol block. It generates its own serial clock from Clock, and frames each word with a command field. It serves up to NUM_CH DAC chips, each with a dedicated Sync line, in one start/busy/done transaction. It sits between the sample generator and the board-level DAC pins.

Parameters:
DATA_W, 12, sample width per channel
CMD_W, 4, command/control field width sent ahead of the sample
FRAME_W, 16, bits per frame; must satisfy FRAME_W >= CMD_W + DATA_W; frame is {cmd, zero pad, data}, MSB first
NUM_CH, 2, number of DAC chips (one Sync each), 1..8
CLK_DIV, 4, Clock cycles per Sclk half-period, >= 1
GAP_CYC, 2, Clock cycles Sync stays high between consecutive frames, >= 1

Ports:
Clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high
start  in  1  request a transaction; sampled only in IDLE
ch_mask  in  NUM_CH  channels to update; bit i = chip i
cmd  in  CMD_W  command field; the same value is used for every frame of the transaction
data_in  in  NUM_CH*DATA_W  channel i sample at [i*DATA_W +: DATA_W]
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse at transaction end
Sync  out  NUM_CH  per-chip frame select, active-low
Sclk  out  1  serial clock; idles high
Data_DAC  out  1  serial data; the DAC samples it on Sclk falling edge

Behaviour:
- Reset (async): state IDLE, Sync all 1, Sclk 1, Data_DAC 0, busy 0, done 0, counters 0. Reset mid-frame aborts the frame immediately; no resume.
- States: IDLE, LOAD, SHIFT, GAP, FIN.
- IDLE: when start=1, capture ch_mask, cmd and data_in into shadow registers.
  - mask != 0: go to LOAD, busy=1 next cycle.
  - mask == 0: go to FIN, so done pulses 2 cycles after start and no Sync toggles.
- start while busy: ignored; shadow data is unaffected by input changes during a transaction.
- LOAD (1 cycle): select the lowest-index pending channel and build its frame. Sync[ch] goes low, Data_DAC = frame MSB, Sclk=1, all on the same edge. Go to SHIFT.
- SHIFT:
  - Half-period counter runs 0..CLK_DIV-1.
  - At each wrap, Sclk toggles.
  - On a rising toggle, Data_DAC advances to the next bit.
  - Data is therefore stable for CLK_DIV cycles on either side of every falling edge.
  - After the FRAME_W-th falling edge, the next half-period ends with Sclk high. On that edge: Sync[ch]=1, Data_DAC=0, clear the channel's pending bit.
  - Sync[ch] low duration = 2*CLK_DIV*FRAME_W + 1 Clock cycles (LOAD cycle included).
  - Then go to GAP if channels remain pending, else FIN.
- GAP: hold all Sync high for GAP_CYC cycles, then go to LOAD.
- FIN: done=1 for exactly one cycle, busy=0 in that same cycle; next state IDLE. A start in the cycle after FIN is accepted.
- Only one Sync is low at any time. Channels are serviced in ascending index order, skipping mask bits of 0.
- Sclk only toggles while a Sync is low. Sclk=1 and Data_DAC=0 whenever all Sync are high.
- Counters: the bit counter is sized ceil(log2(FRAME_W+1)). The divider is sized ceil(log2(CLK_DIV)) with minimum 1; CLK_DIV=1 gives Sclk = Clock/2.
- Illegal parameters (FRAME_W < CMD_W+DATA_W) are flagged by an elaboration-time check.

Test Plan:
- Defaults with CLK_DIV=2, ch_mask=2'b01, cmd=4'h3, data_in ch0=12'hA5C:
  - Sync[0] is low for 65 cycles; Sync[1] stays high.
  - Captured bits on Sclk falling edges = 16'h3A5C.
  - Exactly 16 falling edges; done pulses once.
- ch_mask=2'b11, ch0=12'h001, ch1=12'hFFF, cmd=0:
  - Frame 0x0001 is sent on Sync[0], then exactly 2 cycles with both Sync high, then 0x0FFF on Sync[1].
  - Sync[0] and Sync[1] are never low together.
- ch_mask=0 with start -> done 2 cycles after start; Sync, Sclk and Data_DAC unchanged; busy never high.
- During a frame, pulse start and change data_in to 12'h000:
  - The transmitted word remains the captured value.
  - No second transaction follows.
- reset asserted at the 7th falling edge of Sclk:
  - Same cycle: Sync=all 1, Sclk=1, Data_DAC=0, busy=0.
  - After release, a new start sends a complete, correct frame.
- CLK_DIV=1, NUM_CH=1:
  - Sclk half-period = 1 Clock cycle.
  - Frame 0xFFFF is captured correctly; done is followed immediately by start and is accepted back-to-back.

Source files
------------

// File: rtl/dac_serial_tx_multi.sv
// dac_serial_tx_multi
//   Multi-channel serial DAC transmitter. One start/busy/done transaction
//   sends one frame {cmd, zero pad, sample} MSB first to every chip selected
//   in ch_mask. Chips are served in ascending index order, each on its own
//   active-low Sync. Sclk is generated internally from Clock.
// Ports
//   Clock    : system clock, rising edge
//   reset    : asynchronous, active-high
//   start    : transaction request, sampled only while idle
//   ch_mask  : chips to update (bit i = chip i)
//   cmd      : command field, shared by every frame of the transaction
//   data_in  : chip i sample at [i*DATA_W +: DATA_W]
//   busy     : transaction in progress
//   done     : one-cycle pulse at transaction end
//   Sync     : per-chip frame select, active-low
//   Sclk     : serial clock, idles high
//   Data_DAC : serial data, sampled by the DAC on Sclk falling edge
module dac_serial_tx_multi #(
  parameter int DATA_W  = 12,
  parameter int CMD_W   = 4,
  parameter int FRAME_W = 16,
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2
) (
  input  logic                     Clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [CMD_W-1:0]         cmd,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH-1:0]        Sync,
  output logic                     Sclk,
  output logic                     Data_DAC
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  generate
    if (FRAME_W < CMD_W + DATA_W) begin : g_bad_frame
      $error("dac_serial_tx_multi: FRAME_W must be >= CMD_W + DATA_W");
    end
    if (NUM_CH < 1 || NUM_CH > 8 || CLK_DIV < 1 || GAP_CYC < 1) begin : g_bad_param
      $error("dac_serial_tx_multi: NUM_CH 1..8, CLK_DIV >= 1, GAP_CYC >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_FIN} state_t;
  state_t r_state, w_state_n;

  logic [NUM_CH-1:0]        r_pend;
  logic [CMD_W-1:0]         r_cmd;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic [CH_W-1:0]          r_ch;
  logic [FRAME_W-1:0]       r_shift;
  logic [DIV_W-1:0]         r_div;
  logic [BIT_W-1:0]         r_bits;
  logic [GAP_W-1:0]         r_gap;
  logic                     r_busy, r_done, r_sclk, r_dac;
  logic [NUM_CH-1:0]        r_sync;

  // Channel selection source: the live inputs on the accept edge (so Sync
  // can drop on the very edge that enters LOAD), the shadow copy afterwards.
  logic [NUM_CH-1:0]        w_src_mask;
  logic [CMD_W-1:0]         w_src_cmd;
  logic [NUM_CH*DATA_W-1:0] w_src_data;
  logic [CH_W-1:0]          w_sel;
  logic [DATA_W-1:0]        w_sel_data;
  logic [FRAME_W-1:0]       w_frame;
  logic [NUM_CH-1:0]        w_pend_left;
  logic w_idle, w_accept, w_tick, w_fall, w_rise, w_last, w_gap_end, w_enter_load;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle && start;
  assign w_src_mask = w_idle ? ch_mask : r_pend;
  assign w_src_cmd  = w_idle ? cmd     : r_cmd;
  assign w_src_data = w_idle ? data_in : r_data;

  // lowest set bit wins
  always_comb begin
    w_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_src_mask[i]) w_sel = CH_W'(i);
  end

  assign w_sel_data = w_src_data[w_sel*DATA_W +: DATA_W];
  assign w_frame    = (FRAME_W'(w_src_cmd) << (FRAME_W - CMD_W)) | FRAME_W'(w_sel_data);

  assign w_tick       = (r_state == S_SHIFT) && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_fall       = w_tick &&  r_sclk;
  assign w_rise       = w_tick && !r_sclk;
  // the rise after the last falling edge closes the frame
  assign w_last       = w_rise && (r_bits == BIT_W'(FRAME_W));
  assign w_pend_left  = r_pend & ~(NUM_CH'(1) << r_ch);
  assign w_gap_end    = (r_state == S_GAP) && (r_gap == GAP_W'(GAP_CYC - 1));
  assign w_enter_load = (w_accept && (|ch_mask)) || w_gap_end;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_n = (|ch_mask) ? S_LOAD : S_FIN;
      S_LOAD:  w_state_n = S_SHIFT;
      S_SHIFT: if (w_last) w_state_n = (|w_pend_left) ? S_GAP : S_FIN;
      S_GAP:   if (w_gap_end) w_state_n = S_LOAD;
      S_FIN:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_cmd   <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_shift <= '0;
      r_div   <= '0;
      r_bits  <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b1;
      r_dac   <= 1'b0;
      r_sync  <= '1;
    end else begin
      r_done <= (r_state == S_FIN);
      if (r_state == S_FIN) r_busy <= 1'b0;

      if (w_accept) begin
        r_pend <= ch_mask;
        r_cmd  <= cmd;
        r_data <= data_in;
        r_busy <= |ch_mask;
      end

      if (w_enter_load) begin
        r_ch    <= w_sel;
        r_sync  <= ~(NUM_CH'(1) << w_sel);
        r_sclk  <= 1'b1;
        r_dac   <= w_frame[FRAME_W-1];
        r_shift <= w_frame << 1;
        r_div   <= '0;
        r_bits  <= '0;
      end

      if (r_state == S_SHIFT)
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);

      if (w_fall) begin
        r_sclk <= 1'b0;
        r_bits <= r_bits + BIT_W'(1);
      end

      if (w_rise) begin
        r_sclk <= 1'b1;
        if (w_last) begin
          r_sync <= '1;
          r_dac  <= 1'b0;
          r_pend <= w_pend_left;
          r_gap  <= '0;
        end else begin
          r_dac   <= r_shift[FRAME_W-1];
          r_shift <= r_shift << 1;
        end
      end

      if (r_state == S_GAP) r_gap <= r_gap + GAP_W'(1);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign Sync     = r_sync;
  assign Sclk     = r_sclk;
  assign Data_DAC = r_dac;

endmodule
